// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences datapath strobes, handles memory ready, counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]       st;
  logic [3:0]       nxt;
  logic             retire;
  logic             ill;
  logic [CNT_W-1:0] cnt;

  logic is_lw;
  logic is_mem;
  logic is_r;
  logic is_beq;
  logic is_addi;
  logic is_j;

  assign is_lw   = (opcode == OP_LW);
  assign is_mem  = is_lw | (opcode == OP_SW);
  assign is_r    = (opcode == OP_R);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_j    = (opcode == OP_J);

  always_comb begin
    nxt    = st;
    retire = 1'b0;
    ill    = 1'b0;
    unique case (st)
      FETCH: begin
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = MEMADR;
          is_r:    nxt = RTYPEEX;
          is_beq:  nxt = BEQEX;
          is_addi: nxt = ADDIEX;
          is_j:    nxt = JEX;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR:  nxt = is_lw ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready) nxt = MEMWB;
      end
      MEMWR: begin
        if (mem_ready) begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  logic       mrd_d;
  logic       mw_d;
  logic       irw_d;
  logic       pcw_d;
  logic       br_d;
  logic       rw_d;

  always_comb begin
    mrd_d    = 1'b0;
    mw_d     = 1'b0;
    irw_d    = 1'b0;
    pcw_d    = 1'b0;
    br_d     = 1'b0;
    rw_d     = 1'b0;
    IorD     = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    unique case (st)
      FETCH: begin
        mrd_d   = 1'b1;
        ALUSrcB = 2'b01;
        irw_d   = mem_ready;
        pcw_d   = mem_ready;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        mrd_d = 1'b1;
        IorD  = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        rw_d     = 1'b1;
      end
      MEMWR: begin
        IorD = 1'b1;
        mw_d = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RTYPEWB: begin
        RegDst = 1'b1;
        rw_d   = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        br_d    = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  rw_d = 1'b1;
      JEX: begin
        PCSrc = 2'b10;
        pcw_d = 1'b1;
      end
      default: ;
    endcase
  end

  // reset is asynchronous, so strobes are gated combinationally too
  assign mem_rd     = rst_n & mrd_d;
  assign MemWrite   = rst_n & mw_d;
  assign IRWrite    = rst_n & irw_d;
  assign PCWrite    = rst_n & pcw_d;
  assign Branch     = rst_n & br_d;
  assign RegWrite   = rst_n & rw_d;
  assign illegal_op = rst_n & ill;
  assign state      = st;
  assign retired    = cnt;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and sequences every datapath strobe. It drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract (beq), 10 = decode funct field.
It also handles a memory ready handshake on fetch, load and store, and keeps a count of retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from the instruction register (valid from DECODE onward)
mem_ready  input  1  memory has completed the current read or write this cycle
mem_rd  output  1  memory read request
MemWrite  output  1  memory write request
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  output  1  instruction register load
PCWrite  output  1  unconditional PC load
Branch  output  1  conditional PC load when the ALU zero flag is set
PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  output  2  operation class sent to the ALU control decoder
RegDst  output  1  destination register select: 0 = rt, 1 = rd
MemtoReg  output  1  register write-back source: 0 = ALUOut, 1 = memory data
RegWrite  output  1  register file write enable
illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
state  output  4  current state encoding, for debug
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = FETCH (0) and retired = 0.
  - While rst_n is low, every write or request strobe is forced to 0: mem_rd, MemWrite, IRWrite, PCWrite, Branch, RegWrite.
- Outputs are Moore-decoded from state, except that some strobes are also gated by mem_ready as listed below.
- Any strobe not listed for a state is 0.
- Mux selects not listed for a state are 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- FETCH:
  - Drives mem_rd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target calculation).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH, retired is not incremented.
- MEMADR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Goes to MEMRD if opcode=100011, otherwise MEMWR.
- MEMRD:
  - Drives mem_rd=1, IorD=1.
  - Waits for mem_ready=1, then goes to MEMWB.
- MEMWB: drives RegDst=0, MemtoReg=1, RegWrite=1; goes to FETCH.
- MEMWR:
  - Drives IorD=1 and MemWrite=1; MemWrite is held until mem_ready=1.
  - Goes to FETCH when mem_ready=1.
- RTYPEEX: drives ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to RTYPEWB.
- RTYPEWB: drives RegDst=1, MemtoReg=0, RegWrite=1; goes to FETCH.
- BEQEX: drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; goes to FETCH.
- ADDIEX: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to ADDIWB.
- ADDIWB: drives RegDst=0, MemtoReg=0, RegWrite=1; goes to FETCH.
- JEX: drives PCSrc=10, PCWrite=1; goes to FETCH.
- Retired counter:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX.
  - Wraps modulo 2^CNT_W without saturating.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, beq 3, addi 4, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle and leaves all other outputs unchanged.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
- Reset mid-instruction: the FSM returns immediately to FETCH, the partial instruction is abandoned, and the counter clears.

Test Plan:
- Reset released, mem_ready=1, opcode=000000 -> state sequence 0,1,6,7,0; ALUOp=10 in state 6; RegWrite=1 and RegDst=1 in state 7; retired=1.
- lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> state sequence 0,1,2,3,3,3,4,0; IorD=1 and mem_rd=1 throughout state 3; MemtoReg=1 and RegWrite=1 in state 4.
- sw (101011) with mem_ready low for 1 cycle in FETCH -> IRWrite=0 then 1; MemWrite=1 in state 5 for 1 cycle; no RegWrite pulse; total of 5 cycles.
- beq (000100) then j (000010) -> ALUOp=01, Branch=1, PCSrc=01 in state 8; PCWrite=1, PCSrc=10 in state 11; retired advances by 2.
- Opcode 111111 -> illegal_op high for 1 cycle in DECODE, FSM returns to FETCH, retired unchanged.
- rst_n asserted in RTYPEEX -> state=0, retired=0 and RegWrite=0 in the same cycle; counter preloaded to 2^CNT_W-1 (via force) wraps to 0 after one more addi.
